rst_sequencer: RTL and testbench

//   Sits directly downstream of the arst_sync reset synchronizer and consumes its active-high

---
 rtl/rst_sequencer.sv | 172 +++++++++++++++++
 tb/tb_rst_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rst_sequencer
//  Purpose  : Holds all reset domains asserted for a minimum width after the
//             last reset trigger, waits for clock lock, then releases
//             NUM_STAGES domain resets one at a time, STAGE_GAP cycles apart.
//             Software requests, synchronized reset and lock loss abort the
//             sequence and re-assert every domain.
//  Ports    : in_clk        - single clock
//             in_areset_n   - asynchronous active-low reset
//             in_sync_reset - active-high synchronized reset (in_clk domain)
//             in_locked     - clock-source lock, synchronous to in_clk
//             in_sw_reset   - single-cycle software reset request
//             out_reset     - per-domain active-high resets, bit 0 first out
//             out_done      - high once every stage is released
//             out_state     - current FSM state (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module rst_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int CNT_W       = 8
) (
    input  logic                  in_clk,
    input  logic                  in_areset_n,
    input  logic                  in_sync_reset,
    input  logic                  in_locked,
    input  logic                  in_sw_reset,
    output logic [NUM_STAGES-1:0] out_reset,
    output logic                  out_done,
    output logic [1:0]            out_state
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [1:0] c_ASSERT    = 2'd0;
    localparam logic [1:0] c_WAIT_LOCK = 2'd1;
    localparam logic [1:0] c_RELEASE   = 2'd2;
    localparam logic [1:0] c_RUN       = 2'd3;

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST  = IDX_W'(NUM_STAGES - 1);
    localparam logic             c_SINGLE    = (NUM_STAGES == 1);

    logic [1:0]            r_state_q, w_state_d;
    logic [CNT_W-1:0]      r_cnt_q,   w_cnt_d;
    logic [IDX_W-1:0]      r_idx_q,   w_idx_d;
    logic [NUM_STAGES-1:0] r_reset_q, w_reset_d;
    logic                  r_done_q,  w_done_d;

    logic w_trig;
    logic w_abort;
    logic w_hold_done;
    logic w_gap_done;
    logic w_last_stage;

    // Lock loss only matters once a stage may already be out of reset.
    assign w_trig       = in_sync_reset | in_sw_reset;
    assign w_abort      = w_trig |
                          (~in_locked & ((r_state_q == c_RELEASE) | (r_state_q == c_RUN)));
    assign w_hold_done  = (r_cnt_q == c_HOLD_LAST);
    assign w_gap_done   = (r_cnt_q == c_GAP_LAST);
    assign w_last_stage = (r_idx_q == c_IDX_LAST);

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge in_clk or negedge in_areset_n) begin
        if (!in_areset_n) begin
            r_state_q <= c_ASSERT;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            r_reset_q <= '1;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_idx_q   <= w_idx_d;
            r_reset_q <= w_reset_d;
            r_done_q  <= w_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ASSERT: begin
                if (!w_trig && w_hold_done) w_state_d = c_WAIT_LOCK;
            end
            c_WAIT_LOCK: begin
                if (w_abort)        w_state_d = c_ASSERT;
                else if (in_locked) w_state_d = c_SINGLE ? c_RUN : c_RELEASE;
            end
            c_RELEASE: begin
                if (w_abort)                        w_state_d = c_ASSERT;
                else if (w_gap_done && w_last_stage) w_state_d = c_RUN;
            end
            c_RUN: begin
                if (w_abort) w_state_d = c_ASSERT;
            end
            default: w_state_d = c_ASSERT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_d   = r_cnt_q;
        w_idx_d   = r_idx_q;
        w_reset_d = r_reset_q;
        w_done_d  = r_done_q;
        if ((r_state_q != c_ASSERT) && w_abort) begin
            // Abort wins over any advance; partially released stages go back together.
            w_cnt_d   = '0;
            w_idx_d   = '0;
            w_reset_d = '1;
            w_done_d  = 1'b0;
        end else begin
            case (r_state_q)
                c_ASSERT: begin
                    w_reset_d = '1;
                    w_done_d  = 1'b0;
                    w_idx_d   = '0;
                    if (w_trig || w_hold_done) w_cnt_d = '0;
                    else                       w_cnt_d = r_cnt_q + CNT_W'(1);
                end
                c_WAIT_LOCK: begin
                    if (in_locked) begin
                        // out_reset is a thermometer, so shifting in a zero
                        // releases exactly the next stage (bit idx).
                        w_reset_d = r_reset_q << 1;
                        w_idx_d   = IDX_W'(1);
                        w_cnt_d   = '0;
                        w_done_d  = c_SINGLE;
                    end
                end
                c_RELEASE: begin
                    if (w_gap_done) begin
                        w_reset_d = r_reset_q << 1;
                        w_cnt_d   = '0;
                        w_idx_d   = r_idx_q + IDX_W'(1);
                        w_done_d  = w_last_stage;
                    end else begin
                        w_cnt_d = r_cnt_q + CNT_W'(1);
                    end
                end
                c_RUN: begin
                    w_reset_d = '0;
                    w_done_d  = 1'b1;
                end
                default: begin
                    w_cnt_d   = '0;
                    w_idx_d   = '0;
                    w_reset_d = '1;
                    w_done_d  = 1'b0;
                end
            endcase
        end
    end

    assign out_reset = r_reset_q;
    assign out_done  = r_done_q;
    assign out_state = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rst_sequencer
//  Purpose  : Directed self-checking bench for rst_sequencer (default
//             parameters plus a single-stage, single-hold-cycle instance).
//             Edge N is the N-th rising in_clk edge after in_areset_n
//             deasserts; inputs driven just after edge N are sampled at N+1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rst_sequencer;

    logic       clk = 1'b0;
    logic       areset_n;
    logic       areset1_n;
    logic       sync_reset;
    logic       locked;
    logic       sw_reset;
    logic [3:0] out_reset;
    logic       out_done;
    logic [1:0] out_state;
    logic [0:0] out1_reset;
    logic       out1_done;
    logic [1:0] out1_state;

    int checks   = 0;
    int failures = 0;
    int e        = 0;

    always #5 clk = ~clk;

    rst_sequencer dut (
        .in_clk        (clk),
        .in_areset_n   (areset_n),
        .in_sync_reset (sync_reset),
        .in_locked     (locked),
        .in_sw_reset   (sw_reset),
        .out_reset     (out_reset),
        .out_done      (out_done),
        .out_state     (out_state)
    );

    rst_sequencer #(
        .NUM_STAGES  (1),
        .HOLD_CYCLES (1),
        .STAGE_GAP   (8),
        .CNT_W       (8)
    ) dut1 (
        .in_clk        (clk),
        .in_areset_n   (areset1_n),
        .in_sync_reset (sync_reset),
        .in_locked     (locked),
        .in_sw_reset   (sw_reset),
        .out_reset     (out1_reset),
        .out_done      (out1_done),
        .out_state     (out1_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    // Advance to just after edge n of the current sequence.
    task automatic step_to(input int n);
        while (e < n) begin
            @(posedge clk);
            e++;
        end
        #1;
    endtask

    // Assert the async reset mid-cycle, check the forced values, release between edges.
    task automatic do_reset(input logic lock_val);
        @(negedge clk);
        areset_n   = 1'b0;
        sync_reset = 1'b0;
        sw_reset   = 1'b0;
        locked     = lock_val;
        #2;
        chk("rst_out_reset", {28'd0, out_reset}, 32'hF);
        chk("rst_out_done",  {31'd0, out_done},  32'h0);
        chk("rst_out_state", {30'd0, out_state}, 32'h0);
        @(negedge clk);
        areset_n = 1'b1;
        e = 0;
    endtask

    initial begin
        areset_n   = 1'b0;
        areset1_n  = 1'b0;
        sync_reset = 1'b0;
        locked     = 1'b1;
        sw_reset   = 1'b0;

        // Single stage, single hold cycle
        @(negedge clk);
        #1;
        chk("p1_rst_reset", {31'd0, out1_reset}, 32'h1);
        @(negedge clk);
        areset1_n = 1'b1;
        e = 0;
        step_to(1);
        chk("p1_e1_state", {30'd0, out1_state}, 32'h1);
        chk("p1_e1_reset", {31'd0, out1_reset}, 32'h1);
        step_to(2);
        chk("p1_e2_state", {30'd0, out1_state}, 32'h3);
        chk("p1_e2_reset", {31'd0, out1_reset}, 32'h0);
        chk("p1_e2_done",  {31'd0, out1_done},  32'h1);

        // Normal sequence, then lock loss in RUN
        do_reset(1'b1);
        step_to(15); chk("t1_e15_state", {30'd0, out_state}, 32'h0);
        step_to(16); chk("t1_e16_state", {30'd0, out_state}, 32'h1);
                     chk("t1_e16_reset", {28'd0, out_reset}, 32'hF);
        step_to(17); chk("t1_e17_reset", {28'd0, out_reset}, 32'hE);
                     chk("t1_e17_state", {30'd0, out_state}, 32'h2);
        step_to(24); chk("t1_e24_reset", {28'd0, out_reset}, 32'hE);
        step_to(25); chk("t1_e25_reset", {28'd0, out_reset}, 32'hC);
        step_to(33); chk("t1_e33_reset", {28'd0, out_reset}, 32'h8);
        step_to(40); chk("t1_e40_done",  {31'd0, out_done},  32'h0);
        step_to(41); chk("t1_e41_reset", {28'd0, out_reset}, 32'h0);
                     chk("t1_e41_done",  {31'd0, out_done},  32'h1);
                     chk("t1_e41_state", {30'd0, out_state}, 32'h3);
        step_to(45); locked = 1'b0;
        step_to(46); chk("t5_e46_reset", {28'd0, out_reset}, 32'hF);
                     chk("t5_e46_done",  {31'd0, out_done},  32'h0);
                     chk("t5_e46_state", {30'd0, out_state}, 32'h0);
        locked = 1'b1;

        // Async reset pulse in RUN, between edges
        do_reset(1'b1);
        step_to(41); chk("t6_run_done", {31'd0, out_done}, 32'h1);
        areset_n = 1'b0;
        #2;
        chk("t6_async_reset", {28'd0, out_reset}, 32'hF);
        chk("t6_async_done",  {31'd0, out_done},  32'h0);
        chk("t6_async_state", {30'd0, out_state}, 32'h0);
        areset_n = 1'b1;

        // Late lock: unlocked through ASSERT and WAIT_LOCK
        do_reset(1'b0);
        step_to(16); chk("t2_e16_state", {30'd0, out_state}, 32'h1);
        step_to(30); chk("t2_e30_reset", {28'd0, out_reset}, 32'hF);
                     chk("t2_e30_state", {30'd0, out_state}, 32'h1);
        locked = 1'b1;
        step_to(31); chk("t2_e31_reset", {28'd0, out_reset}, 32'hE);
        step_to(54); chk("t2_e54_done",  {31'd0, out_done},  32'h0);
                     chk("t2_e54_reset", {28'd0, out_reset}, 32'h8);
        step_to(55); chk("t2_e55_done",  {31'd0, out_done},  32'h1);
                     chk("t2_e55_reset", {28'd0, out_reset}, 32'h0);

        // Sync reset sampled at edge 10 restarts the hold count
        do_reset(1'b1);
        step_to(9);  sync_reset = 1'b1;
        step_to(10); sync_reset = 1'b0;
                     chk("t3_e10_state", {30'd0, out_state}, 32'h0);
        step_to(16); chk("t3_e16_state", {30'd0, out_state}, 32'h0);
        step_to(25); chk("t3_e25_state", {30'd0, out_state}, 32'h0);
        step_to(26); chk("t3_e26_state", {30'd0, out_state}, 32'h1);

        // Software reset mid-release; sequence restarts from edge 29
        do_reset(1'b1);
        step_to(28); chk("t4_e28_reset", {28'd0, out_reset}, 32'hC);
        sw_reset = 1'b1;
        step_to(29); sw_reset = 1'b0;
                     chk("t4_e29_reset", {28'd0, out_reset}, 32'hF);
                     chk("t4_e29_done",  {31'd0, out_done},  32'h0);
                     chk("t4_e29_state", {30'd0, out_state}, 32'h0);
        step_to(44); chk("t4_e44_state", {30'd0, out_state}, 32'h0);
        step_to(45); chk("t4_e45_state", {30'd0, out_state}, 32'h1);
        step_to(46); chk("t4_e46_reset", {28'd0, out_reset}, 32'hE);
        step_to(69); chk("t4_e69_done",  {31'd0, out_done},  32'h0);
        step_to(70); chk("t4_e70_done",  {31'd0, out_done},  32'h1);
                     chk("t4_e70_reset", {28'd0, out_reset}, 32'h0);

        // Software reset while waiting for lock
        do_reset(1'b0);
        step_to(20); chk("t8_e20_state", {30'd0, out_state}, 32'h1);
        sw_reset = 1'b1;
        step_to(21); sw_reset = 1'b0;
                     chk("t8_e21_state", {30'd0, out_state}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
